uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Byte FIFO in front of a UART transmitter. The FIFO buffers
//            written bytes. A small FSM hands the bytes one at a time to the
//            transmitter and waits for each frame to finish before it issues
//            the next byte.
// Ports    : i_Clock, i_Reset         clock, synchronous active-high reset
//            i_Wr_DV, i_Wr_Byte       write strobe and data
//            o_Full, o_Empty, o_Level registered FIFO status
//            o_Overflow               sticky flag: a write was dropped
//            o_Tx_DV, o_Tx_Byte       one-cycle start pulse and held byte
//            i_Tx_Active, i_Tx_Done   transmitter handshake
//            o_Busy                   FSM not idle or FIFO not empty
//            o_Sent_Count             completed frames (optional counter)
// Option   : UART_TX_FEEDER_COUNT_EN  builds the sent-frame counter.
//            When it is undefined, o_Sent_Count is tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_feeder #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Wr_DV,
   input  logic [7:0]            i_Wr_Byte,
   output logic                  o_Full,
   output logic                  o_Empty,
   output logic [DEPTH_LOG2:0]   o_Level,
   output logic                  o_Overflow,
   output logic                  o_Tx_DV,
   output logic [7:0]            o_Tx_Byte,
   input  logic                  i_Tx_Active,
   input  logic                  i_Tx_Done,
   output logic                  o_Busy,
   output logic [15:0]           o_Sent_Count
);

   localparam int unsigned            c_DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]    c_LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_END   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              mem_q [c_DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]     level_q, level_d;
   logic                    full_q, empty_q, overflow_q;
   logic                    tx_dv_q, tx_dv_d;
   logic [7:0]              tx_byte_q, tx_byte_d;
   logic                    w_push, w_pop;

   // A write is accepted only against the registered full flag. A pop in the
   // same cycle does not make room for that write.
   assign w_push = i_Wr_DV & ~full_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      w_pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Also hold off while Done is high. A multi-cycle Done pulse, or
            // a frame that was in flight across a reset, must finish before
            // the next byte starts.
            if (!empty_q && !i_Tx_Active && !i_Tx_Done) begin
               w_pop     = 1'b1;
               tx_dv_d   = 1'b1;
               tx_byte_d = mem_q[rd_ptr_q];
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (i_Tx_Active) begin
               state_d = ST_WAIT_END;
            end
         end
         ST_WAIT_END: begin
            if (i_Tx_Done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_comb begin
      level_d = level_q;
      if (w_push && !w_pop) begin
         level_d = level_q + 1'b1;
      end else if (!w_push && w_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset && w_push) begin
         mem_q[wr_ptr_q] <= i_Wr_Byte;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_d;
         full_q  <= (level_d == c_LVL_FULL);
         empty_q <= (level_d == '0);
         if (i_Wr_DV && full_q) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- counter
`ifdef UART_TX_FEEDER_COUNT_EN
   logic [15:0] sent_cnt_q;
   logic        w_frame_done;

   assign w_frame_done = (state_q == ST_WAIT_END) & i_Tx_Done;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sent_cnt_q <= 16'h0000;
      end else if (w_frame_done) begin
         sent_cnt_q <= sent_cnt_q + 16'd1;
      end
   end

   assign o_Sent_Count = sent_cnt_q;
`else
   assign o_Sent_Count = 16'h0000;
`endif

   // ---------------------------------------------------------------- outputs
   assign o_Full     = full_q;
   assign o_Empty    = empty_q;
   assign o_Level    = level_q;
   assign o_Overflow = overflow_q;
   assign o_Tx_DV    = tx_dv_q;
   assign o_Tx_Byte  = tx_byte_q;
   assign o_Busy     = (state_q != ST_IDLE) | ~empty_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Self-checking bench for uart_tx_feeder. It includes a simple
//            transmitter model (4 clocks per bit, 10-bit frame, then Done)
//            and a byte scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_feeder;

   localparam int DEPTH_LOG2 = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                wr_dv;
   logic [7:0]          wr_byte;
   logic                full, empty, overflow, tx_dv, busy;
   logic [DEPTH_LOG2:0] level;
   logic [7:0]          tx_byte;
   logic [15:0]         sent_cnt;
   logic                tx_active;
   logic                tx_act_m, tx_done_m, hold_busy, tx_line;

   int                  n_cmp = 0;
   int                  n_bad = 0;
   logic [7:0]          exp_q[$];
   int                  exp_sent = 0;
   int                  dv_count = 0;
   int                  done_len = 1;
   logic [9:0]          last_frame;
   logic [9:0]          frame_m;
   logic                done_at_pe = 1'b0;
   logic                prev_dv = 1'b0;

   always #5 clk = ~clk;

   assign tx_active = tx_act_m | hold_busy;

   uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .i_Clock      (clk),
      .i_Reset      (rst),
      .i_Wr_DV      (wr_dv),
      .i_Wr_Byte    (wr_byte),
      .o_Full       (full),
      .o_Empty      (empty),
      .o_Level      (level),
      .o_Overflow   (overflow),
      .o_Tx_DV      (tx_dv),
      .o_Tx_Byte    (tx_byte),
      .i_Tx_Active  (tx_active),
      .i_Tx_Done    (tx_done_m),
      .o_Busy       (busy),
      .o_Sent_Count (sent_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef UART_TX_FEEDER_COUNT_EN
      return 32'(n & 16'hFFFF);
`else
      return 32'(n & 0);
`endif
   endfunction

   // Transmitter model: it starts a frame when it sees the start pulse. It
   // shifts out start, 8 data bits LSB first and stop, at 4 clocks per bit.
   // Then it raises Done for done_len cycles.
   initial begin
      tx_act_m   = 1'b0;
      tx_done_m  = 1'b0;
      tx_line    = 1'b1;
      last_frame = '0;
      forever begin
         @(negedge clk);
         if (tx_dv && !rst) begin
            frame_m  = {1'b1, tx_byte, 1'b0};
            tx_act_m = 1'b1;
            for (int b = 0; b < 10; b++) begin
               tx_line       = frame_m[b];
               last_frame[b] = tx_line;
               repeat (4) @(negedge clk);
            end
            tx_line   = 1'b1;
            tx_act_m  = 1'b0;
            tx_done_m = 1'b1;
            repeat (done_len) @(negedge clk);
            tx_done_m = 1'b0;
         end
      end
   end

   // Store the Done value that the DUT sees at each rising edge.
   always @(posedge clk) done_at_pe = tx_done_m;

   // Scoreboard: every start pulse must carry the next expected byte.
   always @(negedge clk) begin
      if (!rst && tx_dv) begin
         dv_count++;
         check_eq("dv_width", prev_dv, 1'b0);
         check_eq("dv_during_done", done_at_pe, 1'b0);
         if (exp_q.size() == 0) check_eq("unexpected_dv", tx_dv, 1'b0);
         else                   check_eq("tx_byte", tx_byte, exp_q.pop_front());
      end
      prev_dv = tx_dv;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wr_dv = 1'b1; wr_byte = 8'hEE;
      @(negedge clk);
      rst = 1'b0; wr_dv = 1'b0;
      exp_q.delete();
      exp_sent = 0;
   endtask

   // Back-to-back writes; only the first n_acc are expected to be accepted.
   task automatic burst(input logic [7:0] first, input int n, input int n_acc);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr_dv = 1'b1; wr_byte = first + 8'(i);
         if (i < n_acc) begin exp_q.push_back(wr_byte); exp_sent++; end
      end
      @(negedge clk);
      wr_dv = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || tx_act_m || tx_done_m || exp_q.size() != 0) && k < 6000) begin
         @(negedge clk); k++;
      end
      check_eq("drain_in_time", 32'(k < 6000), 1);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, g;
      rst = 1'b1; wr_dv = 1'b1; wr_byte = 8'hEE; hold_busy = 1'b0;
      do_reset();
      check_eq("rst_empty", empty, 1);      check_eq("rst_full", full, 0);
      check_eq("rst_level", level, 0);      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_dv", tx_dv, 0);         check_eq("rst_byte", tx_byte, 8'h00);
      check_eq("rst_cnt", sent_cnt, 0);     check_eq("rst_busy", busy, 0);

      // Single byte: latency, serial pattern, count.
      burst(8'hA5, 1, 1);
      check_eq("a5_dv_early", tx_dv, 0);
      check_eq("a5_level", level, 1);
      @(negedge clk);
      check_eq("a5_dv_latency", tx_dv, 1);
      wait_idle();
      check_eq("a5_serial", last_frame, 10'b1101001010);
      check_eq("a5_cnt", sent_cnt, exp_cnt(exp_sent));
      check_eq("a5_empty", empty, 1);
      check_eq("a5_busy", busy, 0);

      // Burst of 16: one pop has already happened, so the FIFO is not full.
      burst(8'h00, 16, 16);
      check_eq("b16_level", level, 15);
      check_eq("b16_full", full, 0);
      wait_idle();
      check_eq("b16_ovf", overflow, 0);
      check_eq("b16_cnt", sent_cnt, exp_cnt(exp_sent));

      // Overflow while the transmitter is held busy.
      hold_busy = 1'b1;
      burst(8'h40, 17, 16);
      check_eq("ovf_level", level, 16);
      check_eq("ovf_full", full, 1);
      check_eq("ovf_flag", overflow, 1);
      hold_busy = 1'b0;
      wait_idle();
      check_eq("ovf_sticky", overflow, 1);
      check_eq("ovf_cnt", sent_cnt, exp_cnt(exp_sent));
      do_reset();
      check_eq("ovf_cleared", overflow, 0);

      // Push and pop in the same cycle at level 3.
      hold_busy = 1'b1;
      burst(8'h80, 3, 3);
      check_eq("pp_level_pre", level, 3);
      @(negedge clk);
      hold_busy = 1'b0; wr_dv = 1'b1; wr_byte = 8'h83;
      exp_q.push_back(8'h83); exp_sent++;
      @(negedge clk);
      wr_dv = 1'b0;
      check_eq("pp_level", level, 3);
      check_eq("pp_pop_dv", tx_dv, 1);

      // 40 bytes through the FIFO, so both pointers wrap.
      for (int i = 0; i < 40; i++) begin
         g = 0;
         while (full && g < 2000) begin @(negedge clk); g++; end
         wr_dv = 1'b1; wr_byte = 8'($urandom);
         exp_q.push_back(wr_byte); exp_sent++;
         @(negedge clk);
         wr_dv = 1'b0;
      end
      wait_idle();
      check_eq("wrap_cnt", sent_cnt, exp_cnt(exp_sent));
      check_eq("wrap_ovf", overflow, 0);

      // Done held high for 2 cycles.
      done_len = 2;
      do_reset();
      burst(8'hC0, 3, 3);
      wait_idle();
      check_eq("done2_cnt", sent_cnt, exp_cnt(3));
      done_len = 1;

      // Reset in WAIT_END with 5 bytes queued.
      do_reset();
      burst(8'hD0, 6, 6);
      g = 0;
      while (!tx_act_m && g < 50) begin @(negedge clk); g++; end
      repeat (10) @(negedge clk);
      check_eq("mid_level", level, 5);
      do_reset();
      check_eq("mid_rst_level", level, 0);
      check_eq("mid_rst_empty", empty, 1);
      check_eq("mid_rst_dv", tx_dv, 0);
      d0 = dv_count;
      g = 0;
      while ((tx_act_m || tx_done_m) && g < 100) begin @(negedge clk); g++; end
      repeat (20) @(negedge clk);
      check_eq("mid_no_dv", dv_count, d0);
      check_eq("mid_cnt", sent_cnt, 0);
      check_eq("mid_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
